// File: rtl/snn_lif_layer.sv
// Fully-connected layer of leaky integrate-and-fire neurons with a runtime-writable signed weight file.
// Define SNN_WTA_INH_EN for lateral inhibition: only the lowest-index threshold crosser fires per step.
module snn_lif_layer #(
    parameter int unsigned N_IN       = 4,
    parameter int unsigned N_OUT      = 2,
    parameter int unsigned WW         = 24,
    parameter int unsigned VW         = 32,
    parameter longint      THRESH     = 4194304,
    parameter int unsigned LEAK_SHIFT = 4,
    parameter int unsigned REFRAC     = 2,
    localparam int unsigned NW        = N_IN * N_OUT,
    localparam int unsigned AW        = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic signed [WW-1:0] wr_data,
    input  logic [N_IN-1:0]      in_spikes,
    input  logic                 step_valid,
    output logic                 step_ready,
    output logic [N_OUT-1:0]     out_spikes,
    output logic                 out_valid,
    output logic                 busy
);

    localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic signed [VW-1:0] THR = VW'(THRESH);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_UPDATE, S_DONE} state_t;

    state_t                state, state_n;
    logic [IW-1:0]         idx;
    logic [N_IN-1:0]       spk;
    logic signed [WW-1:0]  w        [N_IN][N_OUT];
    logic signed [VW-1:0]  acc      [N_OUT];
    logic signed [VW-1:0]  v        [N_OUT];
    logic [RW-1:0]         rc       [N_OUT];
    logic [N_OUT-1:0]      fire_q;
    logic signed [VW-1:0]  acc_sum  [N_OUT];
    logic signed [VW-1:0]  upd_v    [N_OUT];
    logic [RW-1:0]         upd_rc   [N_OUT];
    logic [N_OUT-1:0]      upd_fire;

    // Clamp a two-bit-headroom sum back into the signed VW range.
    function automatic logic signed [VW-1:0] clamp(input logic signed [VW+1:0] x);
        logic signed [VW+1:0] hi;
        logic signed [VW+1:0] lo;
        hi = {3'b000, {(VW-1){1'b1}}};
        lo = {3'b111, {(VW-1){1'b0}}};
        if (x > hi)
            return {1'b0, {(VW-1){1'b1}}};
        else if (x < lo)
            return {1'b1, {(VW-1){1'b0}}};
        else
            return x[VW-1:0];
    endfunction

    assign step_ready = (state == S_IDLE) && en;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (en) begin
            case (state)
                S_IDLE:   if (step_valid) state_n = S_ACCUM;
                S_ACCUM:  if (idx == IW'(N_IN - 1)) state_n = S_UPDATE;
                S_UPDATE: state_n = S_DONE;
                S_DONE:   state_n = S_IDLE;
                default:  state_n = S_IDLE;
            endcase
        end
    end

    // Accumulate, leak, threshold and refractory handling for every neuron in parallel.
    always_comb begin
        logic signed [VW-1:0] vnew;
`ifdef SNN_WTA_INH_EN
        logic found;
        found = 1'b0;
`endif
        upd_fire = '0;
        for (int j = 0; j < N_OUT; j++) begin
            acc_sum[j] = clamp((VW+2)'(acc[j]) + (VW+2)'(w[idx][j]));
            vnew       = clamp((VW+2)'(v[j]) - (VW+2)'(v[j] >>> LEAK_SHIFT) + (VW+2)'(acc[j]));
            upd_v[j]   = vnew;
            upd_rc[j]  = rc[j];
            if (rc[j] != '0) begin
                upd_v[j]  = '0;
                upd_rc[j] = rc[j] - RW'(1);
            end else if (vnew >= THR) begin
                upd_v[j] = '0;
`ifdef SNN_WTA_INH_EN
                if (!found) begin
                    upd_fire[j] = 1'b1;
                    upd_rc[j]   = RW'(REFRAC);
                    found       = 1'b1;
                end
`else
                upd_fire[j] = 1'b1;
                upd_rc[j]   = RW'(REFRAC);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            spk        <= '0;
            fire_q     <= '0;
            out_spikes <= '0;
            out_valid  <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                acc[j] <= '0;
                v[j]   <= '0;
                rc[j]  <= '0;
                for (int i = 0; i < N_IN; i++)
                    w[i][j] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            if (en) begin
                case (state)
                    S_IDLE: begin
                        for (int i = 0; i < N_IN; i++)
                            for (int j = 0; j < N_OUT; j++)
                                if (wr_en && wr_addr == AW'(i * N_OUT + j))
                                    w[i][j] <= wr_data;
                        if (step_valid) begin
                            spk <= in_spikes;
                            idx <= '0;
                            for (int j = 0; j < N_OUT; j++)
                                acc[j] <= '0;
                        end
                    end
                    S_ACCUM: begin
                        if (spk[idx])
                            acc <= acc_sum;
                        idx <= idx + IW'(1);
                    end
                    S_UPDATE: begin
                        v      <= upd_v;
                        rc     <= upd_rc;
                        fire_q <= upd_fire;
                    end
                    S_DONE: begin
                        out_spikes <= fire_q;
                        out_valid  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snn_lif_layer.sv
// Directed bench for snn_lif_layer: firing, leak, refractory, saturation, enable stall, write gating, reset abort.
module tb_snn_lif_layer;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               wr_en;
    logic [2:0]         wr_addr;
    logic signed [23:0] wr_data;
    logic [3:0]         in_spikes;
    logic               step_valid;
    logic               step_ready, out_valid, busy;
    logic [1:0]         out_spikes;
    logic               step_ready25, out_valid25, busy25;
    logic [1:0]         out_spikes25;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    snn_lif_layer dut (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_spikes(in_spikes), .step_valid(step_valid), .step_ready(step_ready),
        .out_spikes(out_spikes), .out_valid(out_valid), .busy(busy)
    );

    snn_lif_layer #(.VW(25)) dut25 (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_spikes(in_spikes), .step_valid(step_valid), .step_ready(step_ready25),
        .out_spikes(out_spikes25), .out_valid(out_valid25), .busy(busy25)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = 3'(addr);
        wr_data = 24'(data);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic accept(input logic [3:0] s);
        check("ready_before_accept", step_ready, 1);
        in_spikes  = s;
        step_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step_valid = 1'b0;
        wr_en      = 1'b0;
    endtask

    // Count rising edges since accept until out_valid is seen; then confirm it is a single-cycle pulse.
    task automatic wait_ov(input int start, output int lat);
        lat = start;
        while (lat < 30) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        check("out_valid_pulse", out_valid, 0);
    endtask

    task automatic step(input logic [3:0] s, input string tag, input logic [1:0] exp_out);
        int lat;
        accept(s);
        wait_ov(0, lat);
        check({tag, "_lat"}, lat, 6);
        check({tag, "_out"}, out_spikes, exp_out);
    endtask

    initial begin
        int lat;
        rst = 1'b1; en = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        in_spikes = '0; step_valid = 1'b0;
        @(negedge clk);
        do_reset();

        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_spikes", out_spikes, 0);
        check("rst_step_ready", step_ready, 1);
        check("rst_w00", dut.w[0][0], 0);

        // Weight write in the accept cycle must already be used by this step.
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 24'(5000000);
        step(4'b0001, "t1", 2'b01);
        check("t1_v0", dut.v[0], 0);
        check("t1_out_hold", out_spikes, 2'b01);
        step(4'b0001, "t2a", 2'b00);
        step(4'b0001, "t2b", 2'b00);
        step(4'b0001, "t2c", 2'b01);

        do_reset();
        wr(0, 3000000);
        step(4'b0001, "t3a", 2'b00);
        check("t3a_v0", dut.v[0], 3000000);
        step(4'b0000, "t3b", 2'b00);
        check("t3b_v0", dut.v[0], 2812500);
        step(4'b0001, "t3c", 2'b01);
        check("t3c_v0", dut.v[0], 0);
        check("t3c_v1", dut.v[1], 0);

        do_reset();
        for (int a = 0; a < 8; a++) wr(a, -8388608);
        step(4'b1111, "t4", 2'b00);
        check("t4_v0_vw25", dut25.v[0], -16777216);
        check("t4_v1_vw25", dut25.v[1], -16777216);
        check("t4_out_vw25", out_spikes25, 2'b00);
        check("t4_v0_vw32", dut.v[0], -33554432);

        do_reset();
        wr(0, 5000000);
        wr(1, 5000000);
`ifdef SNN_WTA_INH_EN
        step(4'b0001, "t6a", 2'b01);
        step(4'b0001, "t6b", 2'b10);
`else
        step(4'b0001, "t6a", 2'b11);
        step(4'b0001, "t6b", 2'b00);
`endif
        check("t6_v1", dut.v[1], 0);

        // Enable stall: five frozen cycles stretch the latency by five.
        do_reset();
        wr(0, 5000000);
        accept(4'b0001);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("stall_busy", busy, 1);
        check("stall_out_valid", out_valid, 0);
        en = 1'b1;
        wait_ov(5, lat);
        check("stall_lat", lat, 11);
        check("stall_out", out_spikes, 2'b01);
        en = 1'b0;
        @(negedge clk);
        check("en0_ready", step_ready, 0);
        en = 1'b1;

        // Writes outside IDLE are dropped; reset aborts a step and clears the weights.
        do_reset();
        wr(0, 5000000);
        step(4'b0001, "t5pre", 2'b01);
        accept(4'b0001);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 24'(77);
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        check("t5_busy_accum", busy, 1);
        check("t5_w00_held", dut.w[0][0], 5000000);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_out_spikes", out_spikes, 0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 2; j++)
                check($sformatf("t5_w%0d%0d", i, j), dut.w[i][j], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
